road_obstacle_scroller: RTL
===========================

// Module: road_obstacle_scroller
// PURPOSE
//  Downstream consumer of the rate-divider tick. On each tick, shifts the road's obstacle grid down one row and spawns a new top row from an LFSR.
//  Checks the bottom row against the player's lane and keeps the survival score.
//  Sits between the game-speed counter and the VGA draw logic; the drawer reads grid_flat after each upd_pulse.
// PARAMETERS
//  LANES      4       lanes across the road (2..8)
//  ROWS       8       visible grid rows (2..16)
//  SPAWN_GAP  2       a new row may spawn only on every SPAWN_GAP-th tick (1 = every tick)
//  SCORE_W    16      score width; saturates at all-ones
// PORTS
//  CLOCK_50     in   1             system clock, all state on rising edge
//  reset        in   1             asynchronous, active-high; clears everything
//  tick         in   1             one-cycle enable from upstream rate divider
//  start        in   1             level; sampled in IDLE and OVER
//  player_lane  in   3             player lane index; values >= LANES clamp to LANES-1
//  grid_flat    out  LANES*ROWS    bit [r*LANES+l] = obstacle at row r, lane l; row 0 is top
//  upd_pulse    out  1             one-cycle pulse, high in the cycle after grid_flat changes
//  score        out  SCORE_W       ticks survived since start
//  game_over    out  1             high while in OVER
//  running      out  1             high in RUN and CHECK
// BEHAVIOUR
//  Reset:
//   - Asynchronous, active-high.
//   - state=IDLE, grid_flat=0, score=0, upd_pulse=0, game_over=0, running=0.
//   - LFSR=16'hACE1, spawn counter=0.
//   - Reset asserted mid-run aborts at once; no pulse is emitted.
//  FSM states: IDLE, RUN, CHECK, OVER.
//   - IDLE: grid and score held at 0. start=1 -> RUN next cycle.
//   - RUN: on tick=1, in the same edge:
//     - grid row r <= row r-1 for r=ROWS-1..1;
//     - row 0 <= spawn mask if the spawn counter is 0, else 0;
//     - spawn counter <= (cnt+1) mod SPAWN_GAP;
//     - LFSR steps once;
//     - state -> CHECK.
//     Without tick, RUN holds.
//   - CHECK (exactly 1 cycle):
//     - upd_pulse=1.
//     - If bottom row bit [player_lane] is 1 -> OVER; score is not incremented.
//     - Otherwise score <= score+1, saturating, and state -> RUN.
//     - A tick arriving in CHECK is dropped. This covers the back-to-back ticks produced when the divider count is 0.
//   - OVER:
//     - game_over=1; grid and score frozen for display.
//     - start=1 -> IDLE, which clears grid, score and spawn counter. LFSR is NOT reseeded.
//  LFSR and spawn mask:
//   - Fibonacci LFSR, 16-bit, taps 16,14,13,11; shift left, feedback into bit 0.
//   - Spawn mask = lfsr[LANES-1:0] sampled before the step.
//   - If the mask is all ones, bit 0 is cleared so one lane always stays open.
//   - The LFSR never reaches 0 from the seed. An all-zero state (which can only arise from an SEU) is forced back to the seed.
//  Timing:
//   - tick-to-grid_flat latency is 1 edge.
//   - tick-to-upd_pulse, score and game_over latency is 2 edges.
//  Simultaneous events:
//   - reset dominates everything.
//   - start is ignored in RUN and CHECK.
//   - tick is ignored outside RUN.
//  player_lane is sampled in CHECK only. Changes between ticks have no effect.
// STRUCTURE
//  Shared package / header (road_pkg):
//   - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_CHECK=2'd2, ST_OVER=2'd3;
//   - LFSR_SEED=16'hACE1, LFSR_TAPS mask;
//   - default LANES/ROWS, so the VGA drawer indexes grid_flat identically.
//  One sub-module: lfsr16 (CLOCK_50, reset, step, seed_load, q[15:0]).
//  Grid shift, FSM, spawn counter and score are kept in this module.
// TESTING
//  1. Reset then start=1 for 1 cycle, tick every 4 cycles, LANES=4, ROWS=8:
//     - first tick -> row0 = 4'b0001 (lfsr[3:0] of 16'hACE1), other rows 0;
//     - upd_pulse 2 cycles after the tick; score=1.
//  2. 8 ticks, player_lane set to a lane the LFSR model leaves empty in the bottom row:
//     - bit-exact grid_flat vs reference model each tick;
//     - score=8, game_over=0.
//  3. Force a collision (player_lane = an occupied bottom lane at tick N):
//     - CHECK -> game_over=1, score unchanged;
//     - further ticks leave grid_flat and score frozen.
//  4. SPAWN_GAP=3, 6 ticks: row 0 non-zero only on ticks 1 and 4. Also force an all-ones mask and check bit 0 is cleared.
//  5. tick held high continuously: grid shifts every 2 cycles; the CHECK-cycle ticks are dropped; upd_pulse alternates.
//  6. Assert reset mid-RUN, 3 cycles after a tick:
//     - all outputs 0 immediately (asynchronous);
//     - after release the state is IDLE, and the first spawn is again 4'b0001.
//     SCORE_W=4 run of 20 safe ticks -> score saturates at 4'hF.

Source files
------------

// File: rtl/road_pkg.sv
// Shared constants for the road obstacle scroller and the VGA drawer that indexes grid_flat.
package road_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned DEF_LANES     = 4;
  localparam int unsigned DEF_ROWS      = 8;
  localparam int unsigned DEF_SPAWN_GAP = 2;
  localparam int unsigned DEF_SCORE_W   = 16;

  // One Fibonacci step: shift left, parity of the tapped bits enters at bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR supplying the obstacle spawn pattern.
module lfsr16
  import road_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        step,
  input  logic        seed_load,
  output logic [15:0] q
);

  logic [15:0] lfsr_q, lfsr_d;

  // Next state: reload, recover from the lock-up state, or advance on step.
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_load || (lfsr_q == '0)) begin
      lfsr_d = LFSR_SEED;
    end else if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // LFSR register, seeded on reset.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/road_obstacle_scroller.sv
// Scrolls the obstacle grid one row per accepted tick, spawns new rows from an LFSR,
// detects a collision with the player's lane and keeps the survival score.
module road_obstacle_scroller
  import road_pkg::*;
#(
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned ROWS      = DEF_ROWS,
  parameter int unsigned SPAWN_GAP = DEF_SPAWN_GAP,
  parameter int unsigned SCORE_W   = DEF_SCORE_W
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     start,
  input  logic [2:0]               player_lane,
  output logic [LANES*ROWS-1:0]    grid_flat,
  output logic                     upd_pulse,
  output logic [SCORE_W-1:0]       score,
  output logic                     game_over,
  output logic                     running
);

  localparam int unsigned GridW = LANES * ROWS;
  localparam int unsigned CntW  = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SPAWN_GAP - 1);
  localparam logic [2:0]      LaneMax = 3'(LANES - 1);

  logic [1:0]         state_q, state_d;
  logic [GridW-1:0]   grid_q, grid_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               upd_q, upd_d;

  logic [15:0]        lfsr;
  logic               lfsr_step;
  logic [LANES-1:0]   spawn_mask;
  logic [LANES-1:0]   new_row;
  logic [LANES-1:0]   bottom_row;
  logic [LANES-1:0]   lane_sel;
  logic [2:0]         lane;
  logic               collide;

  lfsr16 u_lfsr (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .step      (lfsr_step),
    .seed_load (1'b0),
    .q         (lfsr)
  );

  // Spawn pattern from the current LFSR value; never block every lane.
  always_comb begin
    spawn_mask = lfsr[LANES-1:0];
    if (&spawn_mask) begin
      spawn_mask[0] = 1'b0;
    end
  end

  assign new_row    = (cnt_q == '0) ? spawn_mask : '0;
  assign bottom_row = grid_q[GridW-1 -: LANES];
  assign lane       = (player_lane > LaneMax) ? LaneMax : player_lane;
  assign lane_sel   = LANES'(1) << lane;
  assign collide    = |(bottom_row & lane_sel);

  // Game FSM, grid shift, spawn counter and score next-state.
  always_comb begin
    state_d   = state_q;
    grid_d    = grid_q;
    cnt_d     = cnt_q;
    score_d   = score_q;
    upd_d     = 1'b0;
    lfsr_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        grid_d  = '0;
        score_d = '0;
        cnt_d   = '0;
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick) begin
          grid_d    = {grid_q[GridW-LANES-1:0], new_row};
          cnt_d     = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
          lfsr_step = 1'b1;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Ticks arriving here are dropped on purpose.
        upd_d = 1'b1;
        if (collide) begin
          state_d = ST_OVER;
        end else begin
          if (~&score_q) begin
            score_d = score_q + 1'b1;
          end
          state_d = ST_RUN;
        end
      end
      ST_OVER: begin
        // LFSR keeps running state so the next game sees a different road.
        if (start) begin
          grid_d  = '0;
          score_d = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grid_q  <= '0;
      cnt_q   <= '0;
      score_q <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grid_q  <= grid_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      upd_q   <= upd_d;
    end
  end

  assign grid_flat = grid_q;
  assign upd_pulse = upd_q;
  assign score     = score_q;
  assign game_over = (state_q == ST_OVER);
  assign running   = (state_q == ST_RUN) || (state_q == ST_CHECK);

endmodule
